isa_bus_master: RTL

ISA_BUS_MASTER -- requirements
Module: isa_bus_master

---
 rtl/isa_bus_master.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/isa_bus_master.sv
// ISA bus master: turns single request/response transactions into
// ALE/setup/strobe/hold bus cycles with IOCHRDY wait states and timeout.
module isa_bus_master #(
  parameter int          ALE_CYC     = 1,
  parameter int          SETUP_CYC   = 2,
  parameter int          STROBE_CYC  = 4,
  parameter int          HOLD_CYC    = 1,
  parameter logic [15:0] TIMEOUT_MAX = 16'd1000
) (
  input  logic        clk,
  input  logic        busreset_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] bus_a,
  output logic        bus_ale,
  output logic        bus_aen,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  input  logic        bus_rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  localparam logic [15:0] L_ALE = 16'(ALE_CYC - 1);
  localparam logic [15:0] L_SET = 16'(SETUP_CYC - 1);
  localparam logic [15:0] L_STB = 16'(STROBE_CYC - 1);
  localparam logic [15:0] L_HLD = 16'(HOLD_CYC - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_cnt;
  logic [15:0] r_wait;
  logic        r_rdy_m;
  logic        r_rdy_s;
  logic [1:0]  r_type;
  logic [7:0]  r_cap_data;
  logic        r_cap_to;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_timeout;
  logic [19:0] r_bus_a;
  logic        r_bus_ale;
  logic        r_ior_l;
  logic        r_iow_l;
  logic        r_memr_l;
  logic        r_memw_l;
  logic [7:0]  r_d_out;
  logic        r_d_oe;

  logic        w_accept;
  logic        w_end;
  logic        w_to;
  logic        w_wait_inc;
  logic        w_wr_phase;

  assign w_accept = (r_state == S_IDLE) &&
                    req_valid && r_req_ready;

  always_comb begin
    w_nxt      = r_state;
    w_end      = 1'b0;
    w_to       = 1'b0;
    w_wait_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_nxt = S_ALE;
      end
      S_ALE: begin
        if (r_cnt == L_ALE) w_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (r_cnt == L_SET) w_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (r_cnt >= L_STB) begin
          if (r_rdy_s) begin
            w_nxt = S_HOLD;
            w_end = 1'b1;
          end else if (r_wait == TIMEOUT_MAX) begin
            w_nxt = S_HOLD;
            w_end = 1'b1;
            w_to  = 1'b1;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == L_HLD) w_nxt = S_RESP;
      end
      S_RESP: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!busreset_l) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_wait  <= 16'd0;
      r_rdy_m <= 1'b0;
      r_rdy_s <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rdy_m <= bus_rdy;
      r_rdy_s <= r_rdy_m;
      if (w_nxt != r_state)
        r_cnt <= 16'd0;
      else if (r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
      if (w_accept)
        r_wait <= 16'd0;
      else if (w_wait_inc)
        r_wait <= r_wait + 16'd1;
    end
  end

  // Write data is driven for the whole setup-to-hold window.
  assign w_wr_phase = (w_nxt == S_SETUP) ||
                      (w_nxt == S_STROBE) ||
                      (w_nxt == S_HOLD);

  always_ff @(posedge clk) begin
    if (!busreset_l) begin
      r_type        <= 2'b00;
      r_cap_data    <= 8'hFF;
      r_cap_to      <= 1'b0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 8'hFF;
      r_rsp_timeout <= 1'b0;
      r_bus_a       <= 20'd0;
      r_bus_ale     <= 1'b0;
      r_ior_l       <= 1'b1;
      r_iow_l       <= 1'b1;
      r_memr_l      <= 1'b1;
      r_memw_l      <= 1'b1;
      r_d_out       <= 8'd0;
      r_d_oe        <= 1'b0;
    end else begin
      r_req_ready <= (w_nxt == S_IDLE);
      r_rsp_valid <= (w_nxt == S_RESP);
      r_bus_ale   <= (w_nxt == S_ALE);
      r_ior_l  <= !((w_nxt == S_STROBE) &&
                    (r_type == 2'b00));
      r_iow_l  <= !((w_nxt == S_STROBE) &&
                    (r_type == 2'b01));
      r_memr_l <= !((w_nxt == S_STROBE) &&
                    (r_type == 2'b10));
      r_memw_l <= !((w_nxt == S_STROBE) &&
                    (r_type == 2'b11));
      r_d_oe   <= r_type[0] && w_wr_phase;
      if (w_accept) begin
        r_type  <= req_type;
        r_bus_a <= req_addr;
        if (req_type[0]) r_d_out <= req_wdata;
      end
      if (w_end) begin
        r_cap_data <= r_type[0] ? 8'hFF : bus_d_in;
        r_cap_to   <= w_to;
      end
      // Response fields change only as a new response is presented.
      if ((w_nxt == S_RESP) && (r_state != S_RESP)) begin
        r_rsp_rdata   <= r_cap_data;
        r_rsp_timeout <= r_cap_to;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign bus_a       = r_bus_a;
  assign bus_ale     = r_bus_ale;
  assign bus_aen     = 1'b0;
  assign bus_ior_l   = r_ior_l;
  assign bus_iow_l   = r_iow_l;
  assign bus_memr_l  = r_memr_l;
  assign bus_memw_l  = r_memw_l;
  assign bus_d_out   = r_d_out;
  assign bus_d_oe    = r_d_oe;

endmodule
